// File: rtl/sdes_fk_stage.sv
// S-DES round function Fk as a two-stage valid/ready pipeline.
// Stage 1 holds the expanded, key-mixed right nibble; stage 2 holds the finished (optionally swapped) byte.
module sdes_fk_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_subkey,
  input  logic       in_swap,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  // Row is the outer bit pair, column the inner pair; idx = {row, col}.
  function automatic logic [1:0] sbox0(input logic [3:0] b);
    logic [3:0] idx;
    logic [1:0] v;
    idx = {b[3], b[0], b[2], b[1]};
    case (idx)
      4'd0:  v = 2'd1;  4'd1:  v = 2'd0;  4'd2:  v = 2'd3;  4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;  4'd5:  v = 2'd2;  4'd6:  v = 2'd1;  4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;  4'd9:  v = 2'd2;  4'd10: v = 2'd1;  4'd11: v = 2'd3;
      default: case (idx[1:0])
        2'd0:    v = 2'd3;
        2'd1:    v = 2'd1;
        2'd2:    v = 2'd3;
        default: v = 2'd2;
      endcase
    endcase
    return v;
  endfunction

  function automatic logic [1:0] sbox1(input logic [3:0] b);
    logic [3:0] idx;
    logic [1:0] v;
    idx = {b[3], b[0], b[2], b[1]};
    case (idx)
      4'd0:  v = 2'd0;  4'd1:  v = 2'd1;  4'd2:  v = 2'd2;  4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;  4'd5:  v = 2'd0;  4'd6:  v = 2'd1;  4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;  4'd9:  v = 2'd0;  4'd10: v = 2'd1;  4'd11: v = 2'd0;
      default: case (idx[1:0])
        2'd0:    v = 2'd2;
        2'd1:    v = 2'd1;
        2'd2:    v = 2'd0;
        default: v = 2'd3;
      endcase
    endcase
    return v;
  endfunction

  logic       s1Valid;
  logic [3:0] s1L;
  logic [3:0] s1R;
  logic       s1Swap;
  logic [7:0] s1X;
  logic       s2Valid;
  logic [7:0] s2Data;

  logic       stage2Accept;
  logic       s1Advance;
  logic       inFire;
  logic [3:0] inR;
  logic [7:0] expanded;
  logic [3:0] sOut;
  logic [3:0] p4;
  logic [3:0] lNew;
  logic [7:0] fkResult;

  assign stage2Accept = !s2Valid || out_ready;
  assign s1Advance    = s1Valid && stage2Accept;
  assign in_ready     = !s1Valid || s1Advance;
  assign inFire       = in_valid && in_ready;

  assign out_valid = s2Valid;
  assign out_data  = s2Data;

  always_comb begin
    inR      = in_data[3:0];
    expanded = {inR[0], inR[3], inR[2], inR[1], inR[2], inR[1], inR[0], inR[3]};
    sOut     = {sbox0(s1X[7:4]), sbox1(s1X[3:0])};
    p4       = {sOut[2], sOut[0], sOut[1], sOut[3]};
    lNew     = s1L ^ p4;
    fkResult = s1Swap ? {s1R, lNew} : {lNew, s1R};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1L     <= '0;
      s1R     <= '0;
      s1Swap  <= 1'b0;
      s1X     <= '0;
    end else begin
      s1Valid <= inFire || (s1Valid && !s1Advance);
      if (inFire) begin
        s1L    <= in_data[7:4];
        s1R    <= inR;
        s1Swap <= in_swap;
        s1X    <= expanded ^ in_subkey;
      end
    end
  end

  // Data only moves on an advance, so a stalled or drained stage 2 keeps its last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid <= 1'b0;
      s2Data  <= '0;
    end else if (stage2Accept) begin
      s2Valid <= s1Valid;
      if (s1Advance) s2Data <= fkResult;
    end
  end

endmodule

// File: tb/tb_sdes_fk_stage.sv
// Directed, table-driven bench for sdes_fk_stage with an independent Fk reference model.
module tb_sdes_fk_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_subkey;
  logic       in_swap;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int nChecks = 0;
  int nFail   = 0;

  sdes_fk_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_subkey(in_subkey), .in_swap(in_swap),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] key;
    logic       swap;
    logic [7:0] expect_;
  } vec_t;

  // Reference tables laid out row-major, 4 entries per row.
  int s0Tab [16] = '{1,0,3,2, 3,2,1,0, 0,2,1,3, 3,1,3,2};
  int s1Tab [16] = '{0,1,2,3, 2,0,1,3, 3,0,1,0, 2,1,0,3};

  function automatic logic [7:0] refFk(input logic [7:0] d, input logic [7:0] k, input logic sw);
    logic [3:0] l, r, a, b, p, pp, ln;
    logic [7:0] ep, x;
    int ra, ca, rb, cb;
    l  = d[7:4];
    r  = d[3:0];
    // n1 = r[3] ... n4 = r[0]; EP = n4 n1 n2 n3 n2 n3 n4 n1
    ep = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    x  = ep ^ k;
    a  = x[7:4];
    b  = x[3:0];
    ra = 2 * int'(a[3]) + int'(a[0]);
    ca = 2 * int'(a[2]) + int'(a[1]);
    rb = 2 * int'(b[3]) + int'(b[0]);
    cb = 2 * int'(b[2]) + int'(b[1]);
    p[3:2] = 2'(s0Tab[ra*4 + ca]);
    p[1:0] = 2'(s1Tab[rb*4 + cb]);
    pp = {p[2], p[0], p[1], p[3]};
    ln = l ^ pp;
    return sw ? {r, ln} : {ln, r};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offers one transaction with out_ready high and checks 2-cycle latency and result.
  task automatic sendAndCheck(input logic [7:0] d, input logic [7:0] k, input logic sw,
                              input logic [7:0] exp, input string nm);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_subkey = k;
    in_swap   = sw;
    #1;
    check({nm, "_in_ready"}, 8'(in_ready), 8'h01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 8'(lat), 8'd2);
    check({nm, "_data"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [4];
    vecs[0] = '{8'hB6, 8'hA4, 1'b0, 8'h46};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 8'h80};
    vecs[2] = '{8'hB6, 8'hA4, 1'b1, 8'h64};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h08};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_subkey = '0; in_swap = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 8'(out_valid), 8'h00);
    check("reset_out_data", out_data, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 8'(in_ready), 8'h01);

    // Single transactions from the table
    for (int i = 0; i < 4; i++)
      sendAndCheck(vecs[i].data, vecs[i].key, vecs[i].swap, vecs[i].expect_, $sformatf("vec%0d", i));

    // Streaming, out_ready held high
    out_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      if (j <= 4) begin
        in_valid = 1'b1; in_data = vecs[j-1].data; in_subkey = vecs[j-1].key; in_swap = vecs[j-1].swap;
        #1;
        check($sformatf("stream_in_ready%0d", j), 8'(in_ready), 8'h01);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (j >= 2 && j <= 5) begin
        check($sformatf("stream_valid%0d", j), 8'(out_valid), 8'h01);
        check($sformatf("stream_data%0d", j), out_data, vecs[j-2].expect_);
      end else if (j == 6) begin
        check("stream_drained", 8'(out_valid), 8'h00);
      end
    end
    in_valid = 1'b0;

    // Backpressure: fill the pipe with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = vecs[0].data; in_subkey = vecs[0].key; in_swap = vecs[0].swap;
    @(posedge clk); #1;
    in_data = vecs[1].data; in_subkey = vecs[1].key; in_swap = vecs[1].swap;
    check("bp_second_ready", 8'(in_ready), 8'h01);
    @(posedge clk); #1;
    in_data = vecs[2].data; in_subkey = vecs[2].key; in_swap = vecs[2].swap;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp_full_ready%0d", s), 8'(in_ready), 8'h00);
      check($sformatf("bp_hold_valid%0d", s), 8'(out_valid), 8'h01);
      check($sformatf("bp_hold_data%0d", s), out_data, 8'h46);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 8'(in_ready), 8'h01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_out2_valid", 8'(out_valid), 8'h01);
    check("bp_out2_data", out_data, 8'h80);
    @(posedge clk); #1;
    check("bp_out3_valid", 8'(out_valid), 8'h01);
    check("bp_out3_data", out_data, 8'h64);
    @(posedge clk); #1;
    check("bp_drained", 8'(out_valid), 8'h00);

    // Exhaustive S-box sweep: R = 0 so EP(R) = 0 and the subkey is v itself
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vb, d;
      vb = 8'(v);
      d  = {vb[3:0] ^ vb[7:4], 4'h0};
      sendAndCheck(d, vb, 1'b0, refFk(d, vb, 1'b0), $sformatf("sweep%0d", v));
    end

    // Reset with both stages valid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = vecs[0].data; in_subkey = vecs[0].key; in_swap = vecs[0].swap;
    @(posedge clk); #1;
    in_data = vecs[1].data; in_subkey = vecs[1].key; in_swap = vecs[1].swap;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_full_valid", 8'(out_valid), 8'h01);
    check("rst_full_ready", 8'(in_ready), 8'h00);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 8'(out_valid), 8'h00);
    check("rst_async_data", out_data, 8'h00);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_no_stale%0d", c), 8'(out_valid), 8'h00);
    end
    sendAndCheck(vecs[2].data, vecs[2].key, vecs[2].swap, vecs[2].expect_, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
